// File: rtl/cpu_defines.sv
// Shared encodings for the instruction/data memory bus arbiter.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cpu_defines;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // With two requesters, round-robin means "the one that did not go last".
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_INST) ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker (fetch vs data) with a per-port mask.
// Latency: purely combinational; the `last` history register lives in the parent.
// Backpressure: none; the parent only acts on the grant while it is idle.
//
// Ports:
//   req_inst/req_data   raw requests
//   mask_inst/mask_data suppress a port for this cycle (it just completed)
//   last                port granted most recently
//   gnt_vld/gnt_own     a winner exists / which port won
module rr_arb2
    import cpu_defines::*;
(
    input  logic   req_inst,
    input  logic   req_data,
    input  logic   mask_inst,
    input  logic   mask_data,
    input  owner_t last,
    output logic   gnt_vld,
    output owner_t gnt_own
);

    logic elig_inst;
    logic elig_data;

    assign elig_inst = req_inst & ~mask_inst;
    assign elig_data = req_data & ~mask_data;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_own = OWN_INST;
        if (elig_inst && elig_data) begin
            gnt_vld = 1'b1;
            gnt_own = other_owner(last);
        end else if (elig_inst) begin
            gnt_vld = 1'b1;
            gnt_own = OWN_INST;
        end else if (elig_data) begin
            gnt_vld = 1'b1;
            gnt_own = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the data port, one transaction at a time.
// Latency: req -> bus_req is 1 cycle (registered); minimum 3 cycles from grant cycle to done pulse.
// Backpressure: requesters hold req until their done pulse; the slave stalls via bus_addr_ok/bus_data_ok.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_req/i_addr -> i_done/i_rdata   fetch port
//   d_req/d_wr/d_addr/d_wdata/d_wstrb -> d_done/d_rdata   data port
//   bus_req/bus_wr/bus_addr/bus_wdata/bus_wstrb           bus address phase (all registered)
//   bus_addr_ok/bus_data_ok/bus_rdata                     slave handshake
//   busy                             transaction in flight
module mem_bus_arbiter
    import cpu_defines::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_done,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata,
    output logic            busy
);

    state_t          state_q,     state_d;
    owner_t          owner_q,     owner_d;
    owner_t          last_q,      last_d;
    logic            bus_req_q,   bus_req_d;
    logic            bus_wr_q,    bus_wr_d;
    logic [AW-1:0]   bus_addr_q,  bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW/8-1:0] bus_wstrb_q, bus_wstrb_d;
    logic            i_done_q,    i_done_d;
    logic            d_done_q,    d_done_d;
    logic [DW-1:0]   i_rdata_q,   i_rdata_d;
    logic [DW-1:0]   d_rdata_q,   d_rdata_d;

    logic            gnt_vld;
    owner_t          gnt_own;
    logic            complete;

    // A port whose done is high this cycle may still be holding req for the
    // access that just finished, so it is masked to avoid a duplicate grant.
    rr_arb2 u_rr_arb2 (
        .req_inst  (i_req),
        .req_data  (d_req),
        .mask_inst (i_done_q),
        .mask_data (d_done_q),
        .last      (last_q),
        .gnt_vld   (gnt_vld),
        .gnt_own   (gnt_own)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        bus_req_d   = bus_req_q;
        bus_wr_d    = bus_wr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Slave handshakes arriving here belong to nothing and are dropped.
                if (gnt_vld) begin
                    owner_d   = gnt_own;
                    last_d    = gnt_own;
                    bus_req_d = 1'b1;
                    state_d   = ST_ADDR;
                    if (gnt_own == OWN_DATA) begin
                        bus_wr_d    = d_wr;
                        bus_addr_d  = d_addr;
                        bus_wdata_d = d_wdata;
                        bus_wstrb_d = d_wr ? d_wstrb : '0;
                    end else begin
                        bus_wr_d    = 1'b0;
                        bus_addr_d  = i_addr;
                        bus_wdata_d = '0;
                        bus_wstrb_d = '0;
                    end
                end
            end
            ST_ADDR: begin
                // data_ok without addr_ok cannot belong to this access yet.
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    if (bus_data_ok) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (complete) begin
            if (owner_q == OWN_INST) begin
                i_done_d  = 1'b1;
                i_rdata_d = bus_rdata;
            end else begin
                d_done_d = 1'b1;
                // Stores leave the last load result visible to the pipeline.
                if (!bus_wr_q) begin
                    d_rdata_d = bus_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_INST;
            last_q      <= OWN_DATA;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            bus_req_q   <= bus_req_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the pipeline's instruction-fetch port (pcF/instrF side) and data port (memwriteM/aluoutM/writedataM/readdataM side).
- Exactly one transaction is outstanding at a time.
- Latches the winning request, sequences the bus address/data handshake, and returns read data with a one-cycle done pulse to the owning port.
- The pipeline's hazard unit converts `*_req & ~*_done` into stallF/stallD/flushE.

Parameters:
- AW, 32, address width
- DW, 32, data width (DW/8 byte strobes)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held high until i_done
- i_addr  in  AW  fetch address (pcF)
- i_done  out  1  one-cycle pulse: fetch complete
- i_rdata  out  DW  fetch data; valid while i_done=1
- d_req  in  1  data request; held high until d_done
- d_wr  in  1  1=store, 0=load
- d_addr  in  AW  data address (aluoutM)
- d_wdata  in  DW  store data (writedataM)
- d_wstrb  in  DW/8  byte enables for store
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  load data; valid while d_done=1
- bus_req  out  1  bus address-phase request
- bus_wr  out  1  bus write flag
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_wstrb  out  DW/8  bus byte enables (0 on reads)
- bus_addr_ok  in  1  slave accepted address phase
- bus_data_ok  in  1  slave completed data phase
- bus_rdata  in  DW  slave read data; valid with bus_data_ok
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE; owner=INST; last=DATA (so fetch wins first tie); all bus_* outputs 0; i_done=d_done=0; i_rdata=d_rdata=0; busy=0.
- Reset mid-transaction: abandons the transaction. bus_req drops on the next edge, and no done pulse is issued.
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - No request: stay in IDLE.
  - Any request: pick a winner, register its fields into bus_* and owner, go to ADDR.
  - Bus requests therefore leave registered; one cycle from req to bus_req.
  - Arbitration with only one request: that port wins.
  - Arbitration with both requesting: the port not equal to `last` wins (round-robin), then last<=winner.
- ADDR
  - bus_req=1; bus_* fields held constant.
  - bus_addr_ok=1, bus_data_ok=0: bus_req<=0, go to DATA.
  - bus_addr_ok=1, bus_data_ok=1 in the same cycle: completion (see below), go to IDLE.
  - bus_addr_ok=0: stay in ADDR; a bus_data_ok alone is ignored.
- DATA
  - bus_req=0.
  - bus_data_ok=1: completion, go to IDLE. Otherwise wait indefinitely (no timeout).
- Completion
  - Registered: owner's done pulses for exactly the cycle after the completing edge.
  - Owner's rdata<=bus_rdata, held until the next completion of that port.
  - Stores also pulse d_done; d_rdata is not updated on a store.
- Turnaround
  - In the cycle d_done/i_done is high, state is IDLE.
  - The port that just completed is masked from arbitration for that cycle, because its req may still be high for the same access. The other port may be granted.
  - Minimum transaction: 3 cycles from IDLE grant to done (grant edge, ADDR with addr_ok+data_ok, done cycle).
- Ignored inputs
  - Requester fields are sampled only at grant; later changes are ignored.
  - A bus_data_ok or bus_addr_ok arriving in IDLE is ignored.
- bus_wstrb=d_wstrb for stores, 0 for loads and fetches. bus_wr=0 for fetches.
- No combinational path from requester inputs to bus_* outputs.

Decomposition:
- Shared package (cpu_defines):
  - state encodings ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2
  - owner encodings OWN_INST=1'b0, OWN_DATA=1'b1
- One sub-module, rr_arb2: a two-requester round-robin picker with mask input. Purely combinational; the `last` register lives in the parent.
- FSM and request-latch registers are kept in mem_bus_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=0xBFC00000; slave gives addr_ok 1 cycle after bus_req, data_ok 2 cycles later with rdata=0x24080001 -> bus_addr=0xBFC00000, bus_wr=0, bus_wstrb=0; i_done pulses once with i_rdata=0x24080001; d_done stays 0.
- Collision fairness: i_req and d_req high together from reset (d_wr=1, addr 0x80000010, wdata 0xDEADBEEF, wstrb 4'hF) -> fetch granted first; store granted in the turnaround cycle of i_done; bus sees addr 0x80000010, wstrb 4'hF, wdata 0xDEADBEEF; both done pulse exactly once.
- Zero-wait slave: addr_ok and data_ok both asserted in the first ADDR cycle for a load from 0x80000020 returning 0x12345678 -> d_done exactly 2 cycles after grant edge, d_rdata=0x12345678, state never enters DATA.
- Long wait: slave delays addr_ok 5 cycles and data_ok 7 cycles -> bus_req high for exactly 5 cycles with constant fields while requester changes d_addr mid-flight; busy=1 throughout; single done pulse.
- Reset mid-flight: assert rst for 1 cycle while in DATA -> next cycle all outputs 0, state IDLE; a stale bus_data_ok arriving after reset produces no done pulse.
- Byte store: d_wr=1, d_wstrb=4'b0010, d_wdata=0x0000AB00 -> bus_wstrb=4'b0010; d_done pulses; d_rdata keeps its previous value.
